instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_pkg.sv | 19 +
 rtl/instr_loader_if.sv | 22 ++
 rtl/instr_loader.sv | 140 ++++++++++++++
 tb/tb_instr_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: state encoding and stream framing constants.
// LOADER_CHECKSUM_EN adds the CSUM state used for the trailing XOR byte.
package loader_pkg;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
`ifdef LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERROR
  } state_e;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The slave modport is the loader's view of the bus.
interface instr_loader_if;

  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_wr, mem_addr, mem_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_wr, mem_addr, mem_data
  );

endinterface

// File: rtl/instr_loader.sv
// Boot loader: receives a 16-bit word count and little-endian program bytes, then writes 32-bit words to memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module instr_loader
  import loader_pkg::*;
#(
  parameter int unsigned AWIDTH    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic          clk,
  input  logic          rst,
  instr_loader_if.slave bus,
  input  logic          reload,
  output logic          core_rst_n,
  output logic          done,
  output logic          error
);

  localparam logic [31:0] CAP_WORDS = 32'((2 ** AWIDTH) / BYTES_PER_WORD);
  localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);
`ifdef LOADER_CHECKSUM_EN
  localparam state_e TAIL = CSUM;
`else
  localparam state_e TAIL = DONE;
`endif

  state_e                 state_q, state_d;
  logic [8*HDR_BYTES-1:0] n_q, n_d;
  logic [15:0]            word_cnt_q, word_cnt_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [23:0]            pack_q, pack_d;
  logic                   mem_wr_q, mem_wr_d;
  logic [31:0]            mem_addr_q, mem_addr_d;
  logic [31:0]            mem_data_q, mem_data_d;
  logic [15:0]            n_hdr;
  logic                   in_ready;
  logic                   accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             csum_q, csum_d;
`endif

  assign in_ready = (state_q != DONE) && (state_q != ERROR);
  assign accept   = bus.in_valid && in_ready;
  assign n_hdr    = {bus.in_data, n_q[7:0]};

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    pack_d     = pack_q;
    mem_wr_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    if (accept && (state_q == HDR0 || state_q == HDR1 || state_q == DATA))
      csum_d = csum_q ^ bus.in_data;
`endif
    case (state_q)
      HDR0: if (accept) begin
        n_d[7:0] = bus.in_data;
        state_d  = HDR1;
      end
      HDR1: if (accept) begin
        n_d = n_hdr;
        if (32'(n_hdr) > CAP_WORDS) state_d = ERROR;
        else if (n_hdr == 16'd0)    state_d = TAIL;
        else                        state_d = DATA;
      end
      DATA: if (accept) begin
        if (byte_cnt_q == LAST_BYTE) begin
          // Strobe lands the cycle after the 4th byte; in_ready stays high meanwhile.
          mem_wr_d   = 1'b1;
          mem_data_d = {bus.in_data, pack_q};
          mem_addr_d = BASE_ADDR + 32'({word_cnt_q, 2'b00});
          word_cnt_d = word_cnt_q + 16'd1;
          byte_cnt_d = 2'd0;
          if (word_cnt_q == n_q - 16'd1) state_d = TAIL;
        end else begin
          case (byte_cnt_q)
            2'd0:    pack_d[7:0]   = bus.in_data;
            2'd1:    pack_d[15:8]  = bus.in_data;
            default: pack_d[23:16] = bus.in_data;
          endcase
          byte_cnt_d = byte_cnt_q + 2'd1;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: if (accept) state_d = (bus.in_data == csum_q) ? DONE : ERROR;
`endif
      DONE, ERROR: if (reload) begin
        state_d    = HDR0;
        n_d        = '0;
        word_cnt_d = '0;
        byte_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = '0;
`endif
      end
      default: state_d = HDR0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= HDR0;
      n_q        <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      pack_q     <= '0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= BASE_ADDR;
      mem_data_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      pack_q     <= pack_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.mem_wr   = mem_wr_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERROR);
  assign core_rst_n   = (state_q == DONE);

endmodule

// File: tb/tb_instr_loader.sv
// Directed scoreboard bench for instr_loader; expected memory writes are queued as stimulus is sent.
// Checksum-specific steps are included when LOADER_CHECKSUM_EN is defined.
module tb_instr_loader;
  import loader_pkg::*;

  localparam logic [31:0] BASE = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic reload = 1'b0;
  logic core_rst_n, done, error;

  instr_loader_if bus();

  instr_loader #(.AWIDTH(10), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .bus(bus), .reload(reload),
    .core_rst_n(core_rst_n), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] words[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_wr === 1'b1) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL unexpected_wr: observed addr %08h data %08h expected no write", bus.mem_addr, bus.mem_data);
      end
      if (exp_q.size() > 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wr_addr", bus.mem_addr, e[63:32]);
        check("wr_data", bus.mem_data, e[31:0]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    check("in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // Sends header, all of words[], and (if enabled) the correct checksum.
  task automatic load(input logic [15:0] n, input int unsigned gap);
    logic [7:0] x;
    x = n[7:0] ^ n[15:8];
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    for (int k = 0; k < int'(n); k++) begin
      logic [31:0] w;
      w = words[k];
      exp_q.push_back({BASE + 32'(k * 4), w});
      for (int b = 0; b < int'(BYTES_PER_WORD); b++) begin
        x = x ^ w[8*b +: 8];
        send_byte(w[8*b +: 8], gap);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(x, gap);
`endif
    words.delete();
  endtask

  task automatic check_done(input string tag);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_corerst"}, 32'(core_rst_n), 32'd1);
    check({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic drain(input string tag);
    @(negedge clk); #1;
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reload(input string tag);
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_corerst"}, 32'(core_rst_n), 32'd0);
  endtask

  initial begin
    bus.in_data  = '0;
    bus.in_valid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    check("rst_mem_addr", bus.mem_addr, BASE);
    check("rst_mem_data", bus.mem_data, 32'h0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_corerst", 32'(core_rst_n), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Two-word program, back-to-back bytes.
    words = '{32'h00100013, 32'h00200093};
    load(16'd2, 0);
    check_done("n2");
    drain("n2");
    repeat (3) @(posedge clk);
    #1;
    check("n2_hold_addr", bus.mem_addr, BASE + 32'h4);
    check("n2_hold_data", bus.mem_data, 32'h00200093);
    do_reload("rl1");

    // Same program with idle gaps between bytes.
    words = '{32'h00100013, 32'h00200093};
    load(16'd2, 2);
    check_done("gap");
    drain("gap");
    do_reload("rl2");

    // Oversized header: 257 words exceeds 256-word capacity.
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check("ovf_error", 32'(error), 32'd1);
    check("ovf_ready", 32'(bus.in_ready), 32'd0);
    check("ovf_corerst", 32'(core_rst_n), 32'd0);
    check("ovf_done", 32'(done), 32'd0);
    bus.in_data  = 8'h55;
    bus.in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("ovf_stay", 32'(error), 32'd1);
    do_reload("rl3");

    // Zero-length program.
    load(16'd0, 0);
    check_done("n0");
    drain("n0");
    do_reload("rl4");

    // Exactly full capacity.
    for (int k = 0; k < 256; k++) words.push_back($urandom());
    load(16'd256, 0);
    check_done("cap");
    drain("cap");
    check("cap_last_addr", bus.mem_addr, BASE + 32'h3FC);
    do_reload("rl5");

    // Reset in the middle of a word discards the partial word.
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_wr", 32'(bus.mem_wr), 32'd0);
    words = '{32'hDEADBEEF};
    load(16'd1, 0);
    check_done("mid");
    drain("mid");

`ifdef LOADER_CHECKSUM_EN
    do_reload("rl6");
    words = '{32'h00100013};
    load(16'd1, 0);
    check_done("cs_good");
    drain("cs_good");
    do_reload("rl7");
    exp_q.push_back({BASE, 32'h00100013});
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    check("cs_bad_error", 32'(error), 32'd1);
    check("cs_bad_done", 32'(done), 32'd0);
    check("cs_bad_corerst", 32'(core_rst_n), 32'd0);
    drain("cs_bad");
`endif

    repeat (3) @(posedge clk);
    #1;
    check("final_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
